// File: rtl/layer_out_serializer_if.sv
// layer_out_serializer_if: frame input, serialized word output and status flags of the layer serializer
interface layer_out_serializer_if #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16
);
  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data;
  logic                              in_valid;
  logic [DATA_WIDTH-1:0]             out_data;
  logic                              out_valid;
  logic                              out_last;
  logic                              busy;
  logic                              overrun;
  modport master (output in_data, in_valid, input out_data, out_valid, out_last, busy, overrun);
  modport slave  (input in_data, in_valid, output out_data, out_valid, out_last, busy, overrun);
endinterface

// File: rtl/layer_out_serializer.sv
// layer_out_serializer: captures a frame of neuron outputs and streams it one word per cycle.
// Define SER_OVERRUN_DETECT_EN to get the sticky overrun flag; otherwise overrun is tied to 0.
module layer_out_serializer #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16
) (
  input logic                   clk,
  input logic                   rst,
  layer_out_serializer_if.slave bus
);
  localparam int CW = $clog2(NUM_NEURONS) + 1;
  localparam int IW = $clog2(NUM_NEURONS);
  typedef enum logic {IDLE, SEND} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_q [NUM_NEURONS];
  logic                  send, last, accept;
  assign send   = state_q == SEND;
  assign last   = send && cnt_q == CW'(NUM_NEURONS - 1);
  // a new frame is taken only when idle or on the last word, keeping the stream gapless
  assign accept = bus.in_valid && (!send || last);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = accept ? SEND : last ? IDLE : state_q;
    cnt_d   = (accept || last) ? '0 : send ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (accept)
      for (int i = 0; i < NUM_NEURONS; i++)
        buf_q[i] <= bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  assign bus.out_data  = send ? buf_q[cnt_q[IW-1:0]] : '0;
  assign bus.out_valid = send;
  assign bus.out_last  = last;
  assign bus.busy      = send;
`ifdef SER_OVERRUN_DETECT_EN
  logic overrun_q;
  always_ff @(posedge clk) begin
    if (rst) overrun_q <= 1'b0;
    else if (bus.in_valid && send && !last) overrun_q <= 1'b1;
  end
  assign bus.overrun = overrun_q;
`else
  assign bus.overrun = 1'b0;
`endif
endmodule

// File: tb/tb_layer_out_serializer.sv
// tb_layer_out_serializer: scoreboard bench for 4-word and 30-word serializers
module tb_layer_out_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_out_serializer_if #(.NUM_NEURONS(4),  .DATA_WIDTH(16)) b4();
  layer_out_serializer_if #(.NUM_NEURONS(30), .DATA_WIDTH(16)) b30();
  layer_out_serializer #(.NUM_NEURONS(4),  .DATA_WIDTH(16)) dut4  (.clk(clk), .rst(rst), .bus(b4));
  layer_out_serializer #(.NUM_NEURONS(30), .DATA_WIDTH(16)) dut30 (.clk(clk), .rst(rst), .bus(b30));

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } exp_t;
  exp_t q4[$];
  exp_t q30[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic ovr4  = 1'b0;
  bit   mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] frame4(input logic [15:0] base);
    logic [63:0] f;
    for (int i = 0; i < 4; i++) f[i*16 +: 16] = base + 16'(i);
    return f;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (q4.size() > 0) begin
        e = q4.pop_front();
        check("valid4", 32'(b4.out_valid), 32'd1);
        check("data4",  32'(b4.out_data),  32'(e.d));
        check("last4",  32'(b4.out_last),  32'(e.l));
        check("busy4",  32'(b4.busy),      32'd1);
      end else begin
        check("idle_valid4", 32'(b4.out_valid), 32'd0);
        check("idle_data4",  32'(b4.out_data),  32'd0);
        check("idle_last4",  32'(b4.out_last),  32'd0);
        check("idle_busy4",  32'(b4.busy),      32'd0);
      end
      check("overrun4", 32'(b4.overrun), 32'(ovr4));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (q30.size() > 0) begin
        e = q30.pop_front();
        check("valid30", 32'(b30.out_valid), 32'd1);
        check("data30",  32'(b30.out_data),  32'(e.d));
        check("last30",  32'(b30.out_last),  32'(e.l));
      end else begin
        check("idle_valid30", 32'(b30.out_valid), 32'd0);
        check("idle_data30",  32'(b30.out_data),  32'd0);
      end
      check("overrun30", 32'(b30.overrun), 32'd0);
    end
  end

  // one cycle on the 4-word block; acc says whether the strobe should be taken as a new frame
  task automatic step(input bit v, input logic [15:0] base, input bit acc);
    b4.in_valid = v;
    b4.in_data  = frame4(base);
    @(posedge clk);
    if (v && acc)
      for (int i = 0; i < 4; i++) q4.push_back(exp_t'{base + 16'(i), i == 3});
`ifdef SER_OVERRUN_DETECT_EN
    if (v && !acc) ovr4 = 1'b1;
`endif
    @(negedge clk);
    b4.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    q4.delete();
    q30.delete();
    ovr4 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    b4.in_data   = frame4(16'h0900);
    b4.in_valid  = 1'b1;
    b30.in_valid = 1'b1;
    for (int i = 0; i < 30; i++) b30.in_data[i*16 +: 16] = 16'hFF00 - 16'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst          = 1'b0;
    b4.in_valid  = 1'b0;
    b30.in_valid = 1'b0;
    mon_en       = 1'b1;
    repeat (2) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0100, 1'b1);
    repeat (5) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0100, 1'b1);
    repeat (3) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0200, 1'b1);
    repeat (5) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0100, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0300, 1'b0);
    repeat (5) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0100, 1'b1);
    repeat (2) step(1'b0, 16'h0, 1'b0);
    do_reset();
    repeat (3) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0100, 1'b1);
    repeat (5) step(1'b0, 16'h0, 1'b0);
    b30.in_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 30; i++) q30.push_back(exp_t'{16'hFF00 - 16'(i), i == 29});
    @(negedge clk);
    b30.in_valid = 1'b0;
    repeat (33) @(negedge clk);
    check("drain4",  32'(q4.size()),  32'd0);
    check("drain30", 32'(q30.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/layer_out_serializer.md
LAYER_OUT_SERIALIZER -- requirements
Module: layer_out_serializer

Interface
REQ-001 The block SHALL have parameter NUM_NEURONS, default 30, number of neuron outputs captured per layer frame (legal range 2..256).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, width of one neuron output word.
REQ-003 The block SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_data  input  NUM_NEURONS*DATA_WIDTH  concatenated neuron outputs; word i = in_data[i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 The block SHALL have port in_valid  input  1  single-cycle strobe; all in_data words are valid together.
REQ-007 The block SHALL have port out_data  output  DATA_WIDTH  serialized word to the next layer's neuron input bus.
REQ-008 The block SHALL have port out_valid  output  1  out_data valid this cycle; drives the next layer's input-valid.
REQ-009 The block SHALL have port out_last  output  1  high with out_valid on word NUM_NEURONS-1 only.
REQ-010 The block SHALL have port busy  output  1  high while state is SEND.
REQ-011 The block SHALL have port overrun  output  1  sticky error flag (see Configuration).

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE, SEND.
REQ-013 In IDLE with in_valid=1, the block SHALL register all NUM_NEURONS words into an internal frame buffer, clear the word counter to 0, and enter SEND.
REQ-014 In SEND, the block SHALL present buffer word cnt on out_data with out_valid=1 every cycle, with no gaps, incrementing cnt by 1 per cycle.
REQ-015 Latency: for an in_valid accepted at edge N, word i SHALL appear registered at the output in the cycle after edge N+i, for i = 0..NUM_NEURONS-1.
REQ-016 The counter SHALL be $clog2(NUM_NEURONS)+1 bits wide, SHALL never wrap within a frame, and SHALL stop at NUM_NEURONS-1.
REQ-017 When cnt = NUM_NEURONS-1 in SEND, the block SHALL assert out_last and SHALL return to IDLE on the next edge unless a new frame is accepted.
REQ-018 Back-to-back: in_valid=1 in the SEND cycle with out_last=1 SHALL be accepted (buffer reloaded, cnt=0, state stays SEND), so the next frame's word 0 follows the last word with no gap.
REQ-019 in_valid=1 in SEND with out_last=0 SHALL be an overrun: the frame buffer and the in-progress stream SHALL remain unaffected.
REQ-020 While out_valid=0, out_data SHALL hold 0.
REQ-021 There SHALL be no backpressure input; the downstream stage consumes one word per cycle unconditionally.

Reset
REQ-022 rst SHALL force state IDLE, cnt=0, out_valid=0, out_last=0, busy=0, out_data=0, overrun=0.
REQ-023 rst asserted mid-frame SHALL abort the frame; no further words of that frame SHALL be emitted after rst deasserts.
REQ-024 The frame buffer contents need not be reset.
REQ-025 in_valid coincident with rst SHALL be ignored.

Configuration
REQ-026 Macro SER_OVERRUN_DETECT_EN defined: an overrun per REQ-019 SHALL set overrun=1 on the next edge; overrun SHALL hold until rst.
REQ-027 Macro SER_OVERRUN_DETECT_EN undefined: overrun SHALL be constant 0, no detection logic SHALL be present, and the dropped frame SHALL still be ignored as in REQ-019.

Verification
REQ-028 NUM_NEURONS=4, word i=16'h0100+i, in_valid at edge N -> out_valid high after edges N..N+3, out_data 0100,0101,0102,0103, out_last only on 0103, busy then low.
REQ-029 Back-to-back: second frame (16'h0200+i) strobed in the out_last cycle -> eight contiguous valid words 0100..0103, 0200..0203, with out_last on 0103 and 0203.
REQ-030 in_valid during word 1 of a frame -> stream 0100..0103 unchanged; overrun=1 with SER_OVERRUN_DETECT_EN defined, overrun=0 without it.
REQ-031 rst asserted during word 2 -> the next cycle shows out_valid=0, busy=0, overrun=0; a fresh frame after rst streams correctly from word 0.
REQ-032 NUM_NEURONS=30, negative values (16'hFF00-i) -> 30 words emitted in order with sign bits intact; out_last on the 30th word.
